// File: rtl/spi_secondary_framed.sv
// SPI secondary with system-clock oversampling, all four SPI modes, either bit order,
// back-to-back words within one frame and detection of frames that end mid-word.
module spi_secondary_framed #(
  parameter int WORD_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 neg_enable,
  input  logic                 sck,
  input  logic                 in_bit,
  output logic                 out_bit,
  output logic                 word_ready,
  output logic [WORD_BITS-1:0] data_word_received,
  input  logic [WORD_BITS-1:0] data_word_to_send,
  output logic                 frame_abort
);

  localparam int               CNT_W    = $clog2(WORD_BITS) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
  localparam logic             SCK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;
  localparam logic             SAMPLE_ON_RISE = (CPOL == CPHA) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sck_prev_r;
  logic                   cs_prev_r;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [CNT_W-1:0]       bit_cnt_nxt_s;
  logic [WORD_BITS-1:0]   rx_shift_r;
  logic [WORD_BITS-1:0]   rx_shift_nxt_s;
  logic [WORD_BITS-1:0]   tx_shift_r;
  logic [WORD_BITS-1:0]   tx_shift_nxt_s;
  logic [WORD_BITS-1:0]   data_nxt_s;
  logic                   out_bit_nxt_s;
  logic                   word_ready_nxt_s;
  logic                   frame_abort_nxt_s;

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic sck_rise_s;
  logic sck_fall_s;
  logic sample_s;
  logic shift_s;
  logic cs_fall_s;
  logic cs_rise_s;

  // Bit that goes on the wire first for a freshly loaded word.
  function automatic logic first_bit(input logic [WORD_BITS-1:0] w);
    if (MSB_FIRST != 0) begin
      return w[WORD_BITS-1];
    end else begin
      return w[0];
    end
  endfunction

  function automatic logic [WORD_BITS-1:0] shift_out(input logic [WORD_BITS-1:0] w);
    if (MSB_FIRST != 0) begin
      return {w[WORD_BITS-2:0], 1'b0};
    end else begin
      return {1'b0, w[WORD_BITS-1:1]};
    end
  endfunction

  function automatic logic [WORD_BITS-1:0] shift_in(input logic [WORD_BITS-1:0] w,
                                                    input logic b);
    if (MSB_FIRST != 0) begin
      return {w[WORD_BITS-2:0], b};
    end else begin
      return {b, w[WORD_BITS-1:1]};
    end
  endfunction

  // Synchroniser chains and previous-value flops, reset to the idle line levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_r  <= {SYNC_STAGES{SCK_IDLE}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sck_prev_r  <= SCK_IDLE;
      cs_prev_r   <= 1'b1;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], neg_enable};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], in_bit};
      sck_prev_r  <= sck_sync_r[SYNC_STAGES-1];
      cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign cs_s       = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_prev_r;
  assign sck_fall_s = ~sck_s & sck_prev_r;
  assign sample_s   = ~cs_s & (SAMPLE_ON_RISE ? sck_rise_s : sck_fall_s);
  assign shift_s    = ~cs_s & (SAMPLE_ON_RISE ? sck_fall_s : sck_rise_s);
  assign cs_fall_s  = ~cs_s & cs_prev_r;
  assign cs_rise_s  = cs_s & ~cs_prev_r;

  // Next-state and next-output logic for the frame state machine.
  always_comb begin
    state_nxt_s       = state_r;
    bit_cnt_nxt_s     = bit_cnt_r;
    rx_shift_nxt_s    = rx_shift_r;
    tx_shift_nxt_s    = tx_shift_r;
    data_nxt_s        = data_word_received;
    out_bit_nxt_s     = out_bit;
    word_ready_nxt_s  = 1'b0;
    frame_abort_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        bit_cnt_nxt_s = CNT_ZERO;
        if (cs_fall_s) begin
          state_nxt_s    = ACTIVE;
          rx_shift_nxt_s = {WORD_BITS{1'b0}};
          tx_shift_nxt_s = data_word_to_send;
          out_bit_nxt_s  = first_bit(data_word_to_send);
        end else begin
          out_bit_nxt_s = 1'b0;
        end
      end
      ACTIVE: begin
        if (bit_cnt_r == CNT_FULL) begin
          // A completed word is always delivered, even if ~CS rises now.
          word_ready_nxt_s = 1'b1;
          data_nxt_s       = rx_shift_r;
          bit_cnt_nxt_s    = CNT_ZERO;
          tx_shift_nxt_s   = data_word_to_send;
          if (cs_rise_s) begin
            state_nxt_s   = IDLE;
            out_bit_nxt_s = 1'b0;
          end else if (CPHA == 0) begin
            out_bit_nxt_s = first_bit(data_word_to_send);
          end else begin
            out_bit_nxt_s = out_bit;
          end
        end else if (cs_rise_s) begin
          state_nxt_s       = IDLE;
          out_bit_nxt_s     = 1'b0;
          bit_cnt_nxt_s     = CNT_ZERO;
          frame_abort_nxt_s = (bit_cnt_r != CNT_ZERO) ? 1'b1 : 1'b0;
        end else if (sample_s) begin
          rx_shift_nxt_s = shift_in(rx_shift_r, mosi_s);
          bit_cnt_nxt_s  = bit_cnt_r + CNT_ONE;
        end else if (shift_s) begin
          // At a word boundary the shift edge presents bit 0 (CPHA=1) or is skipped (CPHA=0).
          if (bit_cnt_r == CNT_ZERO) begin
            if (CPHA != 0) begin
              out_bit_nxt_s = first_bit(tx_shift_r);
            end else begin
              out_bit_nxt_s = out_bit;
            end
          end else begin
            tx_shift_nxt_s = shift_out(tx_shift_r);
            out_bit_nxt_s  = first_bit(shift_out(tx_shift_r));
          end
        end else begin
          bit_cnt_nxt_s = bit_cnt_r;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        bit_cnt_nxt_s = CNT_ZERO;
        out_bit_nxt_s = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r            <= IDLE;
      bit_cnt_r          <= CNT_ZERO;
      rx_shift_r         <= {WORD_BITS{1'b0}};
      tx_shift_r         <= {WORD_BITS{1'b0}};
      data_word_received <= {WORD_BITS{1'b0}};
      out_bit            <= 1'b0;
      word_ready         <= 1'b0;
      frame_abort        <= 1'b0;
    end else begin
      state_r            <= state_nxt_s;
      bit_cnt_r          <= bit_cnt_nxt_s;
      rx_shift_r         <= rx_shift_nxt_s;
      tx_shift_r         <= tx_shift_nxt_s;
      data_word_received <= data_nxt_s;
      out_bit            <= out_bit_nxt_s;
      word_ready         <= word_ready_nxt_s;
      frame_abort        <= frame_abort_nxt_s;
    end
  end

endmodule

// File: tb/tb_spi_secondary_framed.sv
// Directed bench: four 8-bit instances (modes 0..3, MSB first) and one 16-bit LSB-first
// mode-0 instance, driven by a host model sharing MOSI and a per-instance chip select.
module tb_spi_secondary_framed;

  logic        clk = 1'b0;
  logic        rst;
  logic        csn;
  logic        sck0;
  logic        mosi;
  logic [2:0]  sel;
  logic [7:0]  tx8;
  logic [15:0] tx16;

  logic        wr_m [4];
  logic        ab_m [4];
  logic        miso_m [4];
  logic [7:0]  rx_m [4];
  logic        wr16, ab16, miso16, cs16;
  logic [15:0] rx16;
  logic        miso_sel;

  int  checks = 0;
  int  failures = 0;
  int  wr_cnt [5] = '{default: 0};
  int  ab_cnt [5] = '{default: 0};
  time wr_t [5];
  time last_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    logic cs_g;
    logic sck_g;
    assign cs_g  = (sel == 3'(g)) ? csn : 1'b1;
    assign sck_g = (g >= 2) ? ~sck0 : sck0;
    spi_secondary_framed #(
      .WORD_BITS(8), .SYNC_STAGES(2), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1)
    ) u_dut (
      .clk(clk), .rst(rst), .neg_enable(cs_g), .sck(sck_g), .in_bit(mosi),
      .out_bit(miso_m[g]), .word_ready(wr_m[g]), .data_word_received(rx_m[g]),
      .data_word_to_send(tx8), .frame_abort(ab_m[g])
    );
  end

  assign cs16 = (sel == 3'd4) ? csn : 1'b1;
  spi_secondary_framed #(
    .WORD_BITS(16), .SYNC_STAGES(2), .CPOL(0), .CPHA(0), .MSB_FIRST(0)
  ) u_w16 (
    .clk(clk), .rst(rst), .neg_enable(cs16), .sck(sck0), .in_bit(mosi),
    .out_bit(miso16), .word_ready(wr16), .data_word_received(rx16),
    .data_word_to_send(tx16), .frame_abort(ab16)
  );

  assign miso_sel = (sel == 3'd4) ? miso16 : miso_m[sel[1:0]];

  // Strobe counters, sampled away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_m[i]) begin wr_cnt[i]++; wr_t[i] = $time; end
      if (ab_m[i]) ab_cnt[i]++;
    end
    if (wr16) begin wr_cnt[4]++; wr_t[4] = $time; end
    if (ab16) ab_cnt[4]++;
  end

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_begin(input logic [2:0] s);
    sel = s;
    @(negedge clk);
    csn = 1'b0;
    half();
  endtask

  task automatic frame_end();
    half();
    csn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Host shifts nbits of mosi_word and collects MISO on its mode-correct edge.
  task automatic xfer(input int cpha, input int nbits, input logic msb,
                      input logic [15:0] mosi_word, output logic [15:0] miso_word);
    int idx;
    miso_word = 16'h0000;
    for (int b = 0; b < nbits; b++) begin
      idx = msb ? (nbits - 1 - b) : b;
      if (cpha == 0) begin
        mosi = mosi_word[idx];
        half();
        miso_word[idx] = miso_sel;
        sck0 = 1'b1;
        last_t = $time;
        half();
        sck0 = 1'b0;
      end else begin
        sck0 = 1'b1;
        mosi = mosi_word[idx];
        half();
        miso_word[idx] = miso_sel;
        sck0 = 1'b0;
        last_t = $time;
        half();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; csn = 1'b1; sck0 = 1'b0; mosi = 1'b0; sel = 3'd0;
    tx8 = 8'h00; tx16 = 16'h0000;
    repeat (4) @(negedge clk);
    checks++; if (rx_m[0] !== 8'h00) begin failures++; $display("FAIL reset_rx got=%h exp=00", rx_m[0]); end
    checks++; if (miso_m[0] !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", miso_m[0]); end
    checks++; if ({wr_m[0], ab_m[0], wr16, ab16} !== 4'b0000) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {wr_m[0], ab_m[0], wr16, ab16}); end
    checks++; if (rx16 !== 16'h0000) begin failures++; $display("FAIL reset_rx16 got=%h exp=0000", rx16); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [15:0] m;
    time lat;
    tx8 = 8'hC3;
    frame_begin(3'd0);
    xfer(0, 8, 1'b1, 16'h00A5, m);
    frame_end();
    lat = (wr_t[0] - last_t) / 10;
    checks++; if (rx_m[0] !== 8'hA5) begin failures++; $display("FAIL m0_rx got=%h exp=a5", rx_m[0]); end
    checks++; if (wr_cnt[0] !== 1) begin failures++; $display("FAIL m0_wr_count got=%0d exp=1", wr_cnt[0]); end
    checks++; if (m[7:0] !== 8'hC3) begin failures++; $display("FAIL m0_miso got=%h exp=c3", m[7:0]); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL m0_latency got=%0d exp=4", lat); end
    checks++; if (ab_cnt[0] !== 0) begin failures++; $display("FAIL m0_abort got=%0d exp=0", ab_cnt[0]); end
    checks++; if (miso_m[0] !== 1'b0) begin failures++; $display("FAIL m0_idle_miso got=%b exp=0", miso_m[0]); end
  endtask

  task automatic test_modes123();
    logic [15:0] m;
    tx8 = 8'hC3;
    for (int md = 1; md < 4; md++) begin
      frame_begin(3'(md));
      xfer(md % 2, 8, 1'b1, 16'h00A5, m);
      frame_end();
      checks++; if (rx_m[md] !== 8'hA5) begin failures++; $display("FAIL mode%0d_rx got=%h exp=a5", md, rx_m[md]); end
      checks++; if (wr_cnt[md] !== 1) begin failures++; $display("FAIL mode%0d_wr_count got=%0d exp=1", md, wr_cnt[md]); end
      checks++; if (m[7:0] !== 8'hC3) begin failures++; $display("FAIL mode%0d_miso got=%h exp=c3", md, m[7:0]); end
    end
  endtask

  task automatic test_abort();
    logic [15:0] m;
    frame_begin(3'd0);
    xfer(0, 5, 1'b1, 16'h001F, m);
    frame_end();
    checks++; if (ab_cnt[0] !== 1) begin failures++; $display("FAIL abort_count got=%0d exp=1", ab_cnt[0]); end
    checks++; if (wr_cnt[0] !== 1) begin failures++; $display("FAIL abort_wr_count got=%0d exp=1", wr_cnt[0]); end
    checks++; if (rx_m[0] !== 8'hA5) begin failures++; $display("FAIL abort_rx_held got=%h exp=a5", rx_m[0]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] m1, m2;
    tx8 = 8'hC3;
    frame_begin(3'd0);
    tx8 = 8'h55;
    xfer(0, 8, 1'b1, 16'h0012, m1);
    xfer(0, 8, 1'b1, 16'h0034, m2);
    frame_end();
    checks++; if (wr_cnt[0] !== 3) begin failures++; $display("FAIL b2b_wr_count got=%0d exp=3", wr_cnt[0]); end
    checks++; if (rx_m[0] !== 8'h34) begin failures++; $display("FAIL b2b_rx got=%h exp=34", rx_m[0]); end
    checks++; if (m1[7:0] !== 8'hC3) begin failures++; $display("FAIL b2b_miso1 got=%h exp=c3", m1[7:0]); end
    checks++; if (m2[7:0] !== 8'h55) begin failures++; $display("FAIL b2b_miso2 got=%h exp=55", m2[7:0]); end
    checks++; if (ab_cnt[0] !== 1) begin failures++; $display("FAIL b2b_abort got=%0d exp=1", ab_cnt[0]); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] m;
    tx8 = 8'h00;
    frame_begin(3'd0);
    xfer(0, 3, 1'b1, 16'h00FF, m);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    csn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({rx_m[0], miso_m[0], wr_m[0]} !== 10'h000) begin failures++; $display("FAIL rstmid_state got=%h exp=000", {rx_m[0], miso_m[0], wr_m[0]}); end
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if ({wr_cnt[0], ab_cnt[0]} !== {32'd3, 32'd1}) begin failures++; $display("FAIL rstmid_strobes got=%0d/%0d exp=3/1", wr_cnt[0], ab_cnt[0]); end
    frame_begin(3'd0);
    xfer(0, 8, 1'b1, 16'h007E, m);
    frame_end();
    checks++; if (rx_m[0] !== 8'h7E) begin failures++; $display("FAIL rstmid_rx got=%h exp=7e", rx_m[0]); end
    checks++; if (wr_cnt[0] !== 4) begin failures++; $display("FAIL rstmid_wr_count got=%0d exp=4", wr_cnt[0]); end
  endtask

  task automatic test_w16_lsb();
    logic [15:0] m;
    tx16 = 16'h1234;
    frame_begin(3'd4);
    xfer(0, 16, 1'b0, 16'hBEEF, m);
    frame_end();
    checks++; if (rx16 !== 16'hBEEF) begin failures++; $display("FAIL w16_rx got=%h exp=beef", rx16); end
    checks++; if (m !== 16'h1234) begin failures++; $display("FAIL w16_miso got=%h exp=1234", m); end
    checks++; if (wr_cnt[4] !== 1) begin failures++; $display("FAIL w16_wr_count got=%0d exp=1", wr_cnt[4]); end
    checks++; if (ab_cnt[4] !== 0) begin failures++; $display("FAIL w16_abort got=%0d exp=0", ab_cnt[4]); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes123();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_w16_lsb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
